dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer in front of the single-port data memory.
//  Port 0 = CPU load/store path, port 1 = debug/loader port. Picks one request,
//  drives the memory control/address/data for exactly one cycle, returns read data.
//  Sits between the requesters and the data memory's addr/write_data/MemRead/MemWrite pins.
// PARAMETERS
//  ADDR_W  8   byte-address width of the memory port
//  DATA_W  32  data word width
// PORTS
//  clk         in   1       system clock, all state updates on rising edge
//  reset       in   1       asynchronous, active-high reset
//  req0/req1   in   1       access request; held high with addr/we/wdata stable until gnt
//  we0/we1     in   1       1 = write, 0 = read
//  addr0/addr1 in   ADDR_W  byte address
//  wdata0/1    in   DATA_W  write data
//  gnt0/gnt1   out  1       one-cycle pulse: request accepted (during ACCESS cycle)
//  err0/err1   out  1       one-cycle pulse with gnt: misaligned address, access dropped
//  rvalid0/1   out  1       one-cycle pulse, cycle after gnt of a good read
//  rdata       out  DATA_W  registered read data, valid while rvalid0|rvalid1
//  mem_addr    out  ADDR_W  to memory addr
//  mem_wdata   out  DATA_W  to memory write_data
//  mem_read    out  1       to memory MemRead
//  mem_write   out  1       to memory MemWrite
//  mem_rdata   in   DATA_W  from memory read_data (combinational read)
// BEHAVIOUR
//  - FSM states IDLE, ACCESS. IDLE: if req0|req1, latch winner's addr/we/wdata -> ACCESS.
//    ACCESS: always -> IDLE next cycle. Max throughput one access per 2 cycles.
//  - ACCESS cycle: gnt of winner =1; mem_addr=latched addr; mem_write=we&aligned;
//    mem_read=~we&aligned; mem_wdata=latched wdata. Write commits on ACCESS closing edge.
//  - Read: rdata <= mem_rdata on ACCESS closing edge; rvalidN=1 the following cycle.
//    rdata holds its value until the next read completes.
//  - Alignment: addr[1:0]!=0 -> errN=1 with gntN, mem_read=mem_write=0, no rvalid.
//  - Arbitration (default round-robin): 1-bit pointer, reset 0 (port 0 preferred).
//    Only one req -> that port wins regardless of pointer. Both req -> pointer port wins.
//    After each grant pointer = other port than the winner.
//  - Requester drops req in the cycle after gnt or re-arbitrates; a req held high
//    after gnt is treated as a new request (back-to-back accesses legal).
//  - Outside ACCESS: mem_read=mem_write=0, mem_addr/mem_wdata hold last value.
//  - Reset (async, any state incl. mid-ACCESS): state=IDLE, pointer=0, gnt*/err*/rvalid*=0,
//    mem_read=mem_write=0, mem_addr=0, mem_wdata=0, rdata=0; in-flight access discarded,
//    no grant reported. First possible ACCESS is the 2nd cycle after reset release.
// CONFIGURATION
//  ARB_FIXED_PRIO_EN defined: pointer removed, port 0 always wins on collision
//    (port 1 may starve under continuous req0).
//  Not defined: round-robin as above; neither port waits more than one access.
// TESTING
//  1. Assert reset mid-run -> all outputs 0 immediately, state IDLE, pointer 0.
//  2. req0 we=1 addr 0x10 wdata 0xDEADBEEF, then req0 read 0x10 -> gnt0 each,
//     mem_write=1 one cycle; rvalid0 with rdata 0xDEADBEEF cycle after read gnt.
//  3. After reset req0&req1 reads together, held -> gnt0, then gnt1 2 cycles later,
//     then gnt0 again: strict alternation, rvalid0/rvalid1 match.
//  4. req1 write addr 0x13 -> gnt1+err1 same cycle, mem_write stays 0, mem contents unchanged.
//  5. req1 write 0x20 data 0x1234, reset pulsed during its ACCESS cycle -> mem_write drops
//     asynchronously, no gnt1/rvalid, memory (also reset) reads 0 at 0x20 afterwards.
//  6. ARB_FIXED_PRIO_EN, req0 and req1 held 10 accesses -> only gnt0 seen; drop req0 -> gnt1.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer in front of a single-port data memory.
// Round-robin by default; define ARB_FIXED_PRIO_EN for fixed priority to port 0.
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              err0,
  output logic              err1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state, state_next;
  logic              take;
  logic              winner;
  logic              port;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              access;
  logic              aligned;

`ifndef ARB_FIXED_PRIO_EN
  logic ptr;
`endif

  // Winner selection: a lone requester always wins; a collision goes to the preferred port.
  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    winner = ~req0;
`else
    winner = (req0 & req1) ? ptr : req1;
`endif
  end

  always_comb begin
    state_next = state;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          take       = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign access    = (state == ACCESS);
  assign aligned   = (addr_q[1:0] == 2'b00);
  assign gnt0      = access & ~port;
  assign gnt1      = access & port;
  assign err0      = gnt0 & ~aligned;
  assign err1      = gnt1 & ~aligned;
  assign mem_read  = access & ~we_q & aligned;
  assign mem_write = access & we_q & aligned;
  // The latched request registers double as the memory bus, so the bus holds outside ACCESS.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // NOTE: every state register uses a non-blocking assignment and the async reset
  // clears all of it, so a mid-ACCESS reset kills the in-flight access at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      port    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata   <= '0;
`ifndef ARB_FIXED_PRIO_EN
      ptr     <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      rvalid0 <= mem_read & ~port;
      rvalid1 <= mem_read & port;
      if (mem_read) rdata <= mem_rdata;
      if (take) begin
        port    <= winner;
        we_q    <= winner ? we1 : we0;
        addr_q  <= winner ? addr1 : addr0;
        wdata_q <= winner ? wdata1 : wdata0;
`ifndef ARB_FIXED_PRIO_EN
        ptr     <= ~winner;
`endif
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic
// against a transaction-level model; honours ARB_FIXED_PRIO_EN like the design.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [7:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, err0, err1, rvalid0, rvalid1;
  logic [31:0] rdata;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .err0(err0), .err1(err1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory the arbiter drives: combinational read, write on rising edge, cleared by reset.
  logic [31:0] env_mem [64];
  assign mem_rdata = env_mem[mem_addr[7:2]];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= '0;
    end else if (mem_write) begin
      env_mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the granted transaction of the current cycle (if any), the
  // outcome visible in the following cycle, and the expected memory image.
  logic        m_busy;
  int          m_port;
  logic        m_we;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata;
  int          m_pref;
  logic [7:0]  m_bus_addr;
  logic [31:0] m_bus_wdata;
  logic [1:0]  m_rv;
  logic [31:0] m_rdata;
  logic [31:0] m_mem [64];

  always @(negedge clk) begin
    if (reset) begin
      check("rst_gnt0", gnt0, 0);       check("rst_gnt1", gnt1, 0);
      check("rst_err0", err0, 0);       check("rst_err1", err1, 0);
      check("rst_rvalid0", rvalid0, 0); check("rst_rvalid1", rvalid1, 0);
      check("rst_mem_read", mem_read, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_rdata", rdata, 0);
      m_busy = 0; m_port = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_pref = 0;
      m_bus_addr = 0; m_bus_wdata = 0; m_rv = 0; m_rdata = 0;
      for (int i = 0; i < 64; i++) m_mem[i] = '0;
    end else begin
      automatic logic good = m_busy && (m_addr % 4 == 0);
      check("gnt0", gnt0, m_busy && m_port == 0);
      check("gnt1", gnt1, m_busy && m_port == 1);
      check("err0", err0, m_busy && m_port == 0 && !good);
      check("err1", err1, m_busy && m_port == 1 && !good);
      check("mem_read", mem_read, good && !m_we);
      check("mem_write", mem_write, good && m_we);
      check("mem_addr", mem_addr, m_bus_addr);
      check("mem_wdata", mem_wdata, m_bus_wdata);
      check("rvalid0", rvalid0, m_rv[0]);
      check("rvalid1", rvalid1, m_rv[1]);
      check("rdata", rdata, m_rdata);
      // Outcome of this cycle's access, seen next cycle.
      m_rv = 2'b00;
      if (good && m_we) m_mem[m_addr / 4] = m_wdata;
      if (good && !m_we) begin
        m_rdata = m_mem[m_addr / 4];
        m_rv[m_port] = 1'b1;
      end
      // An access always lasts one cycle; a new one can only start from a free cycle.
      if (m_busy) begin
        m_busy = 0;
      end else if (req0 || req1) begin
        if (req0 && req1) begin
`ifdef ARB_FIXED_PRIO_EN
          m_port = 0;
`else
          m_port = m_pref;
`endif
        end else begin
          m_port = req1 ? 1 : 0;
        end
        m_pref  = 1 - m_port;
        m_busy  = 1;
        m_we    = m_port == 1 ? we1 : we0;
        m_addr  = m_port == 1 ? addr1 : addr0;
        m_wdata = m_port == 1 ? wdata1 : wdata0;
        m_bus_addr  = m_addr;
        m_bus_wdata = m_wdata;
      end
    end
  end

  // Raise one request and hold it until granted; returns at +1 of the grant cycle.
  task automatic issue(input int p, input logic w, input logic [7:0] a, input logic [31:0] d);
    automatic logic got = 0;
    if (p == 0) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if ((p == 0) ? gnt0 : gnt1) begin got = 1; break; end
    end
    if (!got) check("grant_timeout", 0, 1);
    if (p == 0) req0 = 0; else req1 = 0;
  endtask

  task automatic do_reset(input int cycles);
    req0 = 0; req1 = 0;
    reset = 1;
    repeat (cycles) @(posedge clk);
    #1 reset = 0;
  endtask

  function automatic logic [7:0] rand_addr();
    logic [7:0] a;
    a = 8'($urandom_range(0, 15)) << 2;
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  int          seq[$];
  logic        g0, g1;
  logic        got1;

  initial begin
    reset = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("init_gnt0", gnt0, 0);
    check("init_rdata", rdata, 0);
    check("init_mem_addr", mem_addr, 0);
    reset = 0;

    // Write then read back through port 0.
    issue(0, 1'b1, 8'h10, 32'hDEADBEEF);
    check("wr_mem_write", mem_write, 1);
    check("wr_mem_addr", mem_addr, 8'h10);
    issue(0, 1'b0, 8'h10, 32'h0);
    check("rd_mem_read", mem_read, 1);
    @(posedge clk); #1;
    check("rd_rvalid0", rvalid0, 1);
    check("rd_rdata", rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("rd_rvalid0_pulse", rvalid0, 0);
    check("rd_rdata_hold", rdata, 32'hDEADBEEF);

    // Misaligned write from port 1 is dropped with an error.
    issue(1, 1'b1, 8'h13, 32'hFFFFFFFF);
    check("mis_err1", err1, 1);
    check("mis_mem_write", mem_write, 0);
    issue(1, 1'b0, 8'h10, 32'h0);
    @(posedge clk); #1;
    check("mis_rvalid1", rvalid1, 1);
    check("mis_unchanged", rdata, 32'hDEADBEEF);

    // Both ports held: grant order after reset, ten accesses.
    do_reset(2);
    req0 = 1; we0 = 0; addr0 = 8'h04;
    req1 = 1; we1 = 0; addr1 = 8'h08;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (gnt0) seq.push_back(0);
      if (gnt1) seq.push_back(1);
    end
    req0 = 0;
    check("both_grant_count", seq.size(), 10);
    foreach (seq[i]) begin
`ifdef ARB_FIXED_PRIO_EN
      check("fixed_seq", seq[i], 0);
`else
      check("rr_seq", seq[i], i % 2);
`endif
    end
    got1 = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (gnt1) begin got1 = 1; break; end
    end
    check("port1_after_drop", got1, 1);
    req1 = 0;

    // Reset pulsed during a port-1 write's access cycle.
    @(posedge clk); #1;
    issue(1, 1'b1, 8'h20, 32'h00001234);
    #1 reset = 1;
    #1;
    check("rst_async_mem_write", mem_write, 0);
    check("rst_async_gnt1", gnt1, 0);
    @(negedge clk); #2 reset = 0;
    @(posedge clk); #1;
    check("rst_no_rvalid", rvalid1, 0);
    issue(0, 1'b0, 8'h20, 32'h0);
    @(posedge clk); #1;
    check("rst_rd_rvalid0", rvalid0, 1);
    check("rst_rd_zero", rdata, 32'h0);

    // Random traffic; the model checks every cycle.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      g0 = gnt0; g1 = gnt1;
      @(posedge clk); #1;
      if (!req0 || g0) begin
        if ($urandom_range(0, 2) != 0) begin
          req0 = 1; we0 = 1'($urandom_range(0, 1)); addr0 = rand_addr(); wdata0 = $urandom;
        end else req0 = 0;
      end
      if (!req1 || g1) begin
        if ($urandom_range(0, 2) != 0) begin
          req1 = 1; we1 = 1'($urandom_range(0, 1)); addr1 = rand_addr(); wdata1 = $urandom;
        end else req1 = 0;
      end
    end
    req0 = 0; req1 = 0;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
